// File: rtl/generator_sequencer.sv
// Control front-end for the 2-3-9 Q8.8 GAN generator: shadow/active weight store,
// noise-in and pixel-out valid/ready streams, and a timeout guard on the generator.
module generator_sequencer #(
    parameter int DW      = 16,
    parameter int N_L1    = 9,
    parameter int N_L2    = 36,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_addr,
    input  logic [DW-1:0]        cfg_data,
    input  logic                 cfg_commit,
    output logic                 cfg_pending,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_z1,
    input  logic [DW-1:0]        s_z2,
    output logic                 gen_valid_in,
    output logic [DW-1:0]        gen_z1,
    output logic [DW-1:0]        gen_z2,
    output logic [N_L1*DW-1:0]   flat_weights_L1,
    output logic [N_L2*DW-1:0]   flat_weights_L2,
    input  logic                 gen_valid_out,
    input  logic [9*DW-1:0]      gen_pix_flat,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [9*DW-1:0]      m_pix_flat,
    output logic                 err_timeout,
    output logic [15:0]          sample_cnt
);

    localparam int         N_W        = N_L1 + N_L2;
    localparam logic [5:0] ADDR_LIMIT = 6'(N_W);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state;
    logic [DW-1:0] shadow [N_W];
    logic [DW-1:0] active [N_W];
    logic [7:0]    timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_W; k++) shadow[k] <= '0;
        end else if (cfg_we && (cfg_addr < ADDR_LIMIT)) begin
            shadow[cfg_addr] <= cfg_data;
        end
    end

    for (genvar k = 0; k < N_L1; k++) begin : g_l1
        assign flat_weights_L1[DW*k +: DW] = active[k];
    end
    for (genvar k = 0; k < N_L2; k++) begin : g_l2
        assign flat_weights_L2[DW*k +: DW] = active[N_L1+k];
    end

    // s_ready is precomputed one edge early: it is high exactly in IDLE cycles with no commit pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            gen_valid_in <= 1'b0;
            m_valid      <= 1'b0;
            err_timeout  <= 1'b0;
            cfg_pending  <= 1'b0;
            gen_z1       <= '0;
            gen_z2       <= '0;
            m_pix_flat   <= '0;
            sample_cnt   <= '0;
            timer        <= '0;
            for (int k = 0; k < N_W; k++) active[k] <= '0;
        end else begin
            gen_valid_in <= 1'b0;
            err_timeout  <= 1'b0;
            if (cfg_commit) cfg_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (cfg_pending) begin
                        for (int k = 0; k < N_W; k++) active[k] <= shadow[k];
                        cfg_pending <= 1'b0;
                        s_ready     <= 1'b1;
                    end else if (s_valid && s_ready) begin
                        gen_z1       <= s_z1;
                        gen_z2       <= s_z2;
                        s_ready      <= 1'b0;
                        gen_valid_in <= 1'b1;
                        state        <= ISSUE;
                    end else begin
                        s_ready <= !cfg_commit;
                    end
                end
                ISSUE: begin
                    timer <= 8'(TIMEOUT);
                    state <= WAIT;
                end
                WAIT: begin
                    if (gen_valid_out) begin
                        m_pix_flat <= gen_pix_flat;
                        m_valid    <= 1'b1;
                        state      <= HOLD;
                    end else if (timer == 8'd1) begin
                        err_timeout <= 1'b1;
                        s_ready     <= !(cfg_pending || cfg_commit);
                        state       <= IDLE;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid    <= 1'b0;
                        sample_cnt <= sample_cnt + 16'd1;
                        s_ready    <= !(cfg_pending || cfg_commit);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_generator_sequencer.sv
// Directed bench for generator_sequencer: a cycle table for back-to-back samples
// plus hand-written sequences for backpressure, timeout, commit timing and reset.
module tb_generator_sequencer;

    logic         clk;
    logic         rst;
    logic         cfg_we;
    logic [5:0]   cfg_addr;
    logic [15:0]  cfg_data;
    logic         cfg_commit;
    logic         cfg_pending;
    logic         s_valid;
    logic         s_ready;
    logic [15:0]  s_z1;
    logic [15:0]  s_z2;
    logic         gen_valid_in;
    logic [15:0]  gen_z1;
    logic [15:0]  gen_z2;
    logic [143:0] flat_weights_L1;
    logic [575:0] flat_weights_L2;
    logic         gen_valid_out;
    logic [143:0] gen_pix_flat;
    logic         m_valid;
    logic         m_ready;
    logic [143:0] m_pix_flat;
    logic         err_timeout;
    logic [15:0]  sample_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    generator_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .cfg_commit      (cfg_commit),
        .cfg_pending     (cfg_pending),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_z1            (s_z1),
        .s_z2            (s_z2),
        .gen_valid_in    (gen_valid_in),
        .gen_z1          (gen_z1),
        .gen_z2          (gen_z2),
        .flat_weights_L1 (flat_weights_L1),
        .flat_weights_L2 (flat_weights_L2),
        .gen_valid_out   (gen_valid_out),
        .gen_pix_flat    (gen_pix_flat),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_pix_flat      (m_pix_flat),
        .err_timeout     (err_timeout),
        .sample_cnt      (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s_valid;
        logic        gvo;
        logic        m_ready;
        logic [15:0] z1;
        logic [15:0] z2;
        logic        e_s_ready;
        logic        e_gv_in;
        logic        e_m_valid;
        logic        e_err;
        logic        e_pending;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t         vecs [11];
    logic [143:0] pix_a;
    logic [143:0] pix_b;
    logic [15:0]  exp_z1;
    logic [15:0]  exp_z2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [575:0] actual, input logic [575:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        s_valid       = v.s_valid;
        gen_valid_out = v.gvo;
        m_ready       = v.m_ready;
        s_z1          = v.z1;
        s_z2          = v.z2;
    endtask

    task automatic acceptSample(input logic [15:0] z1, input logic [15:0] z2);
        checkOutput("accept s_ready", 576'(s_ready), 576'(1'b1));
        s_valid = 1'b1;
        s_z1    = z1;
        s_z2    = z2;
        tick();
        s_valid = 1'b0;
        checkOutput("accept gen_valid_in", 576'(gen_valid_in), 576'(1'b1));
        checkOutput("accept gen_z", 576'({gen_z1, gen_z2}), 576'({z1, z2}));
    endtask

    // Drives one generator response in the current WAIT cycle and checks its capture.
    task automatic respond(input logic [143:0] pix);
        gen_valid_out = 1'b1;
        gen_pix_flat  = pix;
        tick();
        gen_valid_out = 1'b0;
        checkOutput("respond m_valid", 576'(m_valid), 576'(1'b1));
        checkOutput("respond m_pix", 576'(m_pix_flat), 576'(pix));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cycles;
        logic saw_mvalid;

        for (int n = 1; n <= 9; n++) begin
            pix_a[16*(n-1) +: 16] = 16'(n);
            pix_b[16*(n-1) +: 16] = 16'(16'h1000 + 16'(n * 3));
        end

        //           s_v   gvo   m_rdy z1        z2        s_rdy gv_in m_val err   pend  cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h0100, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'h0A0A, 16'h0B0B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        s_valid = 1'b0; s_z1 = '0; s_z2 = '0; gen_valid_out = 1'b0; gen_pix_flat = pix_a; m_ready = 1'b0;
        exp_z1 = '0; exp_z2 = '0;
        tick();
        tick();
        checkOutput("reset s_ready", 576'(s_ready), 576'(1'b0));
        checkOutput("reset m_valid", 576'(m_valid), 576'(1'b0));
        checkOutput("reset pending", 576'(cfg_pending), 576'(1'b0));
        checkOutput("reset cnt", 576'(sample_cnt), 576'(16'd0));
        checkOutput("reset L1", 576'(flat_weights_L1), 576'(144'd0));
        rst = 1'b0;
        tick();
        checkOutput("post-reset s_ready", 576'(s_ready), 576'(1'b1));

        // Weight load; the final write shares its cycle with the commit and must be included.
        for (int k = 0; k < 45; k++) begin
            cfg_we     = 1'b1;
            cfg_addr   = 6'(k);
            cfg_data   = 16'(k * 16);
            cfg_commit = (k == 44);
            tick();
        end
        cfg_we = 1'b0; cfg_commit = 1'b0;
        checkOutput("load pending", 576'(cfg_pending), 576'(1'b1));
        checkOutput("load copy-cycle s_ready", 576'(s_ready), 576'(1'b0));
        checkOutput("load L2[35] before copy", 576'(flat_weights_L2[35*16 +: 16]), 576'(16'h0000));
        tick();
        checkOutput("load pending cleared", 576'(cfg_pending), 576'(1'b0));
        checkOutput("load L1[0]", 576'(flat_weights_L1[15:0]), 576'(16'h0000));
        checkOutput("load L1[8]", 576'(flat_weights_L1[8*16 +: 16]), 576'(16'h0080));
        checkOutput("load L2[0]", 576'(flat_weights_L2[15:0]), 576'(16'h0090));
        checkOutput("load L2[35]", 576'(flat_weights_L2[35*16 +: 16]), 576'(16'h02C0));

        for (int r = 0; r < 11; r++) begin
            checkOutput($sformatf("row%0d s_ready", r), 576'(s_ready), 576'(vecs[r].e_s_ready));
            checkOutput($sformatf("row%0d gen_valid_in", r), 576'(gen_valid_in), 576'(vecs[r].e_gv_in));
            checkOutput($sformatf("row%0d m_valid", r), 576'(m_valid), 576'(vecs[r].e_m_valid));
            checkOutput($sformatf("row%0d err_timeout", r), 576'(err_timeout), 576'(vecs[r].e_err));
            checkOutput($sformatf("row%0d pending", r), 576'(cfg_pending), 576'(vecs[r].e_pending));
            checkOutput($sformatf("row%0d sample_cnt", r), 576'(sample_cnt), 576'(vecs[r].e_cnt));
            if (vecs[r].e_gv_in)
                checkOutput($sformatf("row%0d gen_z", r), 576'({gen_z1, gen_z2}), 576'({exp_z1, exp_z2}));
            if (vecs[r].e_m_valid)
                checkOutput($sformatf("row%0d m_pix", r), 576'(m_pix_flat), 576'(pix_a));
            applyStimulus(vecs[r]);
            if (vecs[r].s_valid && vecs[r].e_s_ready) begin
                exp_z1 = vecs[r].z1;
                exp_z2 = vecs[r].z2;
            end
            tick();
        end

        // Backpressure: result must hold while m_ready stays low.
        acceptSample(16'h0200, 16'h0300);
        tick();
        m_ready = 1'b0;
        respond(pix_b);
        gen_pix_flat = ~pix_b;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("hold%0d m_valid", i), 576'(m_valid), 576'(1'b1));
            checkOutput($sformatf("hold%0d m_pix", i), 576'(m_pix_flat), 576'(pix_b));
            checkOutput($sformatf("hold%0d s_ready", i), 576'(s_ready), 576'(1'b0));
            checkOutput($sformatf("hold%0d cnt", i), 576'(sample_cnt), 576'(16'd2));
            tick();
        end
        m_ready = 1'b1;
        tick();
        checkOutput("release m_valid", 576'(m_valid), 576'(1'b0));
        checkOutput("release cnt", 576'(sample_cnt), 576'(16'd3));
        checkOutput("release s_ready", 576'(s_ready), 576'(1'b1));
        tick();
        checkOutput("release cnt once", 576'(sample_cnt), 576'(16'd3));

        // Timeout: 16 WAIT cycles follow the ISSUE cycle, then the pulse lands in IDLE.
        acceptSample(16'h1111, 16'h2222);
        cycles = 0;
        saw_mvalid = 1'b0;
        while (cycles < 40 && !err_timeout) begin
            tick();
            cycles++;
            if (m_valid) saw_mvalid = 1'b1;
        end
        checkOutput("timeout latency", 576'(cycles), 576'(17));
        checkOutput("timeout no m_valid", 576'(saw_mvalid), 576'(1'b0));
        checkOutput("timeout s_ready", 576'(s_ready), 576'(1'b1));
        checkOutput("timeout cnt", 576'(sample_cnt), 576'(16'd3));
        tick();
        checkOutput("timeout one-cycle pulse", 576'(err_timeout), 576'(1'b0));
        checkOutput("timeout s_ready next", 576'(s_ready), 576'(1'b1));

        // Response on the very last WAIT cycle beats the timeout.
        acceptSample(16'h3333, 16'h4444);
        repeat (16) tick();
        respond(pix_a);
        checkOutput("last-wait no err", 576'(err_timeout), 576'(1'b0));
        tick();
        checkOutput("last-wait cnt", 576'(sample_cnt), 576'(16'd4));
        checkOutput("last-wait err after", 576'(err_timeout), 576'(1'b0));

        // Commit during WAIT is deferred until the sequencer is back in IDLE.
        acceptSample(16'h0400, 16'h0500);
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 16'h1234;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checkOutput("wait-commit pending", 576'(cfg_pending), 576'(1'b1));
        checkOutput("wait-commit L1[0] stable", 576'(flat_weights_L1[15:0]), 576'(16'h0000));
        m_ready = 1'b0;
        respond(pix_b);
        checkOutput("hold L1[0] stable", 576'(flat_weights_L1[15:0]), 576'(16'h0000));
        m_ready = 1'b1;
        tick();
        checkOutput("copy-cycle s_ready", 576'(s_ready), 576'(1'b0));
        checkOutput("copy-cycle pending", 576'(cfg_pending), 576'(1'b1));
        checkOutput("copy-cycle L1[0]", 576'(flat_weights_L1[15:0]), 576'(16'h0000));
        checkOutput("copy-cycle cnt", 576'(sample_cnt), 576'(16'd5));
        s_valid = 1'b1; s_z1 = 16'h0600; s_z2 = 16'h0700;
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_data = 16'h5555;
        tick();
        cfg_we = 1'b0;
        checkOutput("post-copy L1[0]", 576'(flat_weights_L1[15:0]), 576'(16'h1234));
        checkOutput("post-copy L1[1] excludes copy-cycle write", 576'(flat_weights_L1[31:16]), 576'(16'h0010));
        checkOutput("post-copy pending", 576'(cfg_pending), 576'(1'b0));
        checkOutput("post-copy no issue", 576'(gen_valid_in), 576'(1'b0));
        checkOutput("post-copy s_ready", 576'(s_ready), 576'(1'b1));
        tick();
        s_valid = 1'b0;
        checkOutput("deferred accept gen_valid_in", 576'(gen_valid_in), 576'(1'b1));
        checkOutput("deferred accept gen_z", 576'({gen_z1, gen_z2}), 576'({16'h0600, 16'h0700}));
        tick();
        respond(pix_a);
        tick();
        checkOutput("deferred cnt", 576'(sample_cnt), 576'(16'd6));
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checkOutput("second commit s_ready", 576'(s_ready), 576'(1'b0));
        tick();
        checkOutput("second commit L1[1]", 576'(flat_weights_L1[31:16]), 576'(16'h5555));

        // Reset while holding a result, then an out-of-range write.
        acceptSample(16'h0777, 16'h0888);
        tick();
        m_ready = 1'b0;
        respond(pix_b);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("hold-reset m_valid", 576'(m_valid), 576'(1'b0));
        checkOutput("hold-reset L1", 576'(flat_weights_L1), 576'(144'd0));
        checkOutput("hold-reset L2", 576'(flat_weights_L2), 576'(576'd0));
        checkOutput("hold-reset cnt", 576'(sample_cnt), 576'(16'd0));
        checkOutput("hold-reset s_ready", 576'(s_ready), 576'(1'b0));
        cfg_we = 1'b1; cfg_addr = 6'd50; cfg_data = 16'hAAAA; cfg_commit = 1'b1;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b0;
        checkOutput("addr50 pending", 576'(cfg_pending), 576'(1'b1));
        tick();
        checkOutput("addr50 L1", 576'(flat_weights_L1), 576'(144'd0));
        checkOutput("addr50 L2", 576'(flat_weights_L2), 576'(576'd0));
        checkOutput("addr50 pending cleared", 576'(cfg_pending), 576'(1'b0));
        checkOutput("addr50 s_ready", 576'(s_ready), 576'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
